// File: rtl/interboard_tx_scheduler.sv
// Two-port priority scheduler feeding a shared FIFO into the interboard link handshake.
// Optional per-attempt timeout with retransmit/drop, enabled by macro TX_SCHED_RETRY_EN.
module interboard_tx_scheduler #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 1000000,
  parameter int MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     p0_valid,
  input  logic [2:0]               p0_msg_type,
  input  logic [4:0]               p0_number,
  output logic                     p0_ready,
  input  logic                     p1_valid,
  input  logic [2:0]               p1_msg_type,
  input  logic [4:0]               p1_number,
  output logic                     p1_ready,
  input  logic                     inter_ready,
  output logic                     transmit,
  output logic                     ctrl_en,
  output logic [2:0]               ctrl_msg_type,
  output logic [4:0]               ctrl_number,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;
  logic            transmit_q;
  logic            ctrl_en_q;
  logic [2:0]      ctrl_type_q;
  logic [4:0]      ctrl_num_q;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            done;
  logic [7:0]      push_data;
  logic [7:0]      head;

`ifdef TX_SCHED_RETRY_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [TW-1:0]   tmr_q;
  logic [RW-1:0]   retry_q;
  logic            err_drop_q;
  logic            tmo;
  logic            drop;

  assign err_drop = err_drop_q;
`else
  logic            unused_cfg;

  assign unused_cfg = ^{TIMEOUT[0], MAX_RETRY[0]};
  assign err_drop   = 1'b0;
`endif

  always_comb begin
    full      = (level_q == LW'(DEPTH));
    empty     = (level_q == '0);
    p0_ready  = !full && !flush;
    p1_ready  = !full && !flush && !p0_valid;
    push      = (p0_valid && p0_ready) || (p1_valid && p1_ready);
    push_data = p0_valid ? {p0_msg_type, p0_number} : {p1_msg_type, p1_number};
    head      = mem_q[rd_ptr_q];
    done      = (state_q == S_WAIT_DONE) && inter_ready;
`ifdef TX_SCHED_RETRY_EN
    // A completing handshake always wins over an expiring timer.
    tmo  = !done && ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE))
           && (tmr_q <= TW'(1));
    drop = tmo && (retry_q == RW'(MAX_RETRY));
    pop  = !flush && (done || drop);
`else
    pop  = !flush && done;
`endif
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      transmit_q  <= 1'b0;
      ctrl_en_q   <= 1'b0;
      ctrl_type_q <= '0;
      ctrl_num_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef TX_SCHED_RETRY_EN
      tmr_q       <= '0;
      retry_q     <= '0;
      err_drop_q  <= 1'b0;
`endif
    end else if (flush) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      transmit_q  <= 1'b0;
      ctrl_en_q   <= 1'b0;
      ctrl_type_q <= '0;
      ctrl_num_q  <= '0;
`ifdef TX_SCHED_RETRY_EN
      tmr_q       <= '0;
      retry_q     <= '0;
      err_drop_q  <= 1'b0;
`endif
    end else begin
      level_q    <= level_d;
      transmit_q <= 1'b0;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (!empty && inter_ready) begin
            state_q     <= S_SEND;
            transmit_q  <= 1'b1;
            ctrl_en_q   <= 1'b1;
            ctrl_type_q <= head[7:5];
            ctrl_num_q  <= head[4:0];
`ifdef TX_SCHED_RETRY_EN
            tmr_q       <= TW'(TIMEOUT);
`endif
          end
        end
        S_SEND: state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (!inter_ready) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (inter_ready) begin
            state_q     <= S_IDLE;
            ctrl_en_q   <= 1'b0;
            ctrl_type_q <= '0;
            ctrl_num_q  <= '0;
`ifdef TX_SCHED_RETRY_EN
            retry_q     <= '0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef TX_SCHED_RETRY_EN
      err_drop_q <= 1'b0;
      if (state_q != S_IDLE && tmr_q != '0) tmr_q <= tmr_q - 1'b1;
      // Timeout abandons the attempt; the head stays queued unless retries are spent.
      if (tmo) begin
        state_q     <= S_IDLE;
        ctrl_en_q   <= 1'b0;
        ctrl_type_q <= '0;
        ctrl_num_q  <= '0;
        if (drop) begin
          retry_q    <= '0;
          err_drop_q <= 1'b1;
        end else begin
          retry_q    <= retry_q + 1'b1;
        end
      end
`endif
    end
  end

  assign transmit      = transmit_q;
  assign ctrl_en       = ctrl_en_q;
  assign ctrl_msg_type = ctrl_type_q;
  assign ctrl_number   = ctrl_num_q;
  assign level         = level_q;

endmodule
